// File: rtl/dx_reg_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dx_reg_skid : two-entry registered valid/ready skid stage with flush      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dx_reg_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            occ_q, occ_d;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    always_comb begin
        w_in_xfer   = in_valid & in_ready_q;
        w_out_xfer  = out_valid_q & out_ready;
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occ_d       = 2'd0;

        // Flush discards everything, including any handshake this cycle.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        main_d = in_data;
                    end else if (w_in_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (w_out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Handshake outputs are registered copies of the next state.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        case (state_d)
            ST_BUSY: occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_dx_reg_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dx_reg_skid : randomized and directed checks against a FIFO model      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_dx_reg_skid;

    logic        clk = 1'b0;
    logic        rs  = 1'b0;
    logic        fl  = 1'b0;

    logic        v8 = 1'b0, ordy8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occ8;

    logic        v32 = 1'b0, ordy32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        in_ready32, out_valid32;
    logic [31:0] out_data32;
    logic [1:0]  occ32;

    int total = 0;
    int bad   = 0;
    bit mirror = 1'b1;

    // Behavioural model: an ordered list of stored words plus handshake flags.
    logic [31:0] q8[$];
    logic [31:0] q32[$];
    bit          rdy8 = 0, vld8 = 0, rdy32 = 0, vld32 = 0;

    always #5 clk = ~clk;

    dx_reg_skid #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rs), .flush(fl),
        .in_data(d8), .in_valid(v8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(ordy8),
        .occupancy(occ8)
    );

    dx_reg_skid #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rs), .flush(fl),
        .in_data(d32), .in_valid(v32), .in_ready(in_ready32),
        .out_data(out_data32), .out_valid(out_valid32), .out_ready(ordy32),
        .occupancy(occ32)
    );

    // Advance one clock and update the model from the inputs held before the edge.
    task automatic tick();
        bit ix8, ox8, ix32, ox32;
        if (mirror) begin
            v32    = v8;
            d32    = {4{d8}};
            ordy32 = ordy8;
        end
        ix8  = v8 && rdy8;
        ox8  = ordy8 && vld8;
        ix32 = v32 && rdy32;
        ox32 = ordy32 && vld32;
        @(posedge clk);
        if (!rs) begin
            q8.delete();
            q32.delete();
            rdy8 = 0; rdy32 = 0;
        end else if (fl) begin
            q8.delete();
            q32.delete();
            rdy8 = 1; rdy32 = 1;
        end else begin
            if (ox8)  void'(q8.pop_front());
            if (ix8)  q8.push_back({24'h0, d8});
            if (ox32) void'(q32.pop_front());
            if (ix32) q32.push_back(d32);
            rdy8  = (q8.size() < 2);
            rdy32 = (q32.size() < 2);
        end
        vld8  = (q8.size() > 0);
        vld32 = (q32.size() > 0);
        #1;
    endtask

    task automatic drain();
        v8 = 0; ordy8 = 1; fl = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rs = 0; v8 = 1; d8 = 8'hAA; ordy8 = 1;
        repeat (5) begin
            tick();
            total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid8); end
            total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready8); end
            total++; if (occ8 !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occ8); end
            total++; if (out_data8 !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data8); end
        end
        rs = 1;
        tick();
        total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0h exp=1", in_ready8); end
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL release_no_accept got=%0h exp=0", out_valid8); end
        total++; if (occ8 !== 2'd0) begin bad++; $display("FAIL release_occ got=%0d exp=0", occ8); end
        v8 = 0;
        tick();
    endtask

    task automatic test_stream();
        drain();
        ordy8 = 1;
        for (int i = 1; i <= 32; i++) begin
            v8 = 1; d8 = i[7:0];
            tick();
            total++; if (out_valid8 !== 1'b1 || out_data8 !== i[7:0]) begin
                bad++; $display("FAIL stream_data got=%0h/%0h exp=1/%0h", out_valid8, out_data8, i[7:0]);
            end
            total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL stream_in_ready got=%0h exp=1", in_ready8); end
            total++; if (occ8 !== 2'd1) begin bad++; $display("FAIL stream_occ got=%0d exp=1", occ8); end
        end
        v8 = 0;
        tick();
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0h exp=0", out_valid8); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] exp_seq[3];
        int         wi;
        exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h12;
        drain();
        wi = 0;
        for (int c = 0; c < 10; c++) begin
            ordy8 = !(c >= 1 && c <= 3);
            v8    = (wi < 3);
            d8    = 8'h10 + wi[7:0];
            if (out_valid8 && ordy8) got.push_back(out_data8);
            if (v8 && rdy8) wi++;
            tick();
            total++; if (occ8 !== 2'(q8.size()) || in_ready8 !== rdy8 || out_valid8 !== vld8) begin
                bad++; $display("FAIL bp_state c=%0d got occ=%0d rdy=%0h vld=%0h exp occ=%0d rdy=%0h vld=%0h",
                                c, occ8, in_ready8, out_valid8, q8.size(), rdy8, vld8);
            end
            if (c >= 1 && c <= 3) begin
                total++; if (occ8 !== 2'd2 || in_ready8 !== 1'b0 || out_data8 !== 8'h10) begin
                    bad++; $display("FAIL bp_hold c=%0d got occ=%0d rdy=%0h data=%0h exp occ=2 rdy=0 data=10",
                                    c, occ8, in_ready8, out_data8);
                end
            end
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            total++; if (k >= got.size() || got[k] !== exp_seq[k]) begin
                bad++; $display("FAIL bp_order k=%0d got=%0h exp=%0h", k, (k < got.size()) ? got[k] : 8'hxx, exp_seq[k]);
            end
        end
    endtask

    task automatic test_random();
        drain();
        mirror = 0;
        for (int c = 0; c < 2000; c++) begin
            v8     = 1'($urandom_range(0, 1));
            d8     = 8'($urandom);
            ordy8  = ($urandom_range(0, 3) != 0);
            v32    = ($urandom_range(0, 2) != 0);
            d32    = $urandom;
            ordy32 = 1'($urandom_range(0, 1));
            tick();
            total++; if (out_valid8 !== vld8 || in_ready8 !== rdy8 || occ8 !== 2'(q8.size())) begin
                bad++; $display("FAIL rand8_ctrl c=%0d got v=%0h r=%0h o=%0d exp v=%0h r=%0h o=%0d",
                                c, out_valid8, in_ready8, occ8, vld8, rdy8, q8.size());
            end
            if (vld8) begin
                total++; if (out_data8 !== q8[0][7:0]) begin
                    bad++; $display("FAIL rand8_data c=%0d got=%0h exp=%0h", c, out_data8, q8[0][7:0]);
                end
            end
            total++; if (out_valid32 !== vld32 || in_ready32 !== rdy32 || occ32 !== 2'(q32.size())) begin
                bad++; $display("FAIL rand32_ctrl c=%0d got v=%0h r=%0h o=%0d exp v=%0h r=%0h o=%0d",
                                c, out_valid32, in_ready32, occ32, vld32, rdy32, q32.size());
            end
            if (vld32) begin
                total++; if (out_data32 !== q32[0]) begin
                    bad++; $display("FAIL rand32_data c=%0d got=%0h exp=%0h", c, out_data32, q32[0]);
                end
            end
        end
        mirror = 1;
    endtask

    task automatic test_flush();
        drain();
        ordy8 = 0; v8 = 1; d8 = 8'h33; tick();
        d8 = 8'h44; tick();
        total++; if (occ8 !== 2'd2) begin bad++; $display("FAIL flush_fill got=%0d exp=2", occ8); end
        fl = 1; v8 = 1; d8 = 8'h55; ordy8 = 1;
        tick();
        fl = 0;
        total++; if (out_valid8 !== 1'b0 || occ8 !== 2'd0 || in_ready8 !== 1'b1) begin
            bad++; $display("FAIL flush_clear got v=%0h o=%0d r=%0h exp v=0 o=0 r=1", out_valid8, occ8, in_ready8);
        end
        v8 = 1; d8 = 8'h66;
        tick();
        total++; if (out_valid8 !== 1'b1 || out_data8 !== 8'h66) begin
            bad++; $display("FAIL flush_next got=%0h/%0h exp=1/66", out_valid8, out_data8);
        end
        v8 = 0;
        tick();
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL flush_drain got=%0h exp=0", out_valid8); end
    endtask

    task automatic test_mid_reset();
        for (int pass = 0; pass < 2; pass++) begin
            drain();
            ordy8 = 0; v8 = 1; d8 = 8'h71; tick();
            d8 = 8'h72; tick();
            total++; if (occ8 !== 2'd2) begin bad++; $display("FAIL mrst_fill p=%0d got=%0d exp=2", pass, occ8); end
            rs = 0; fl = (pass == 1);
            tick();
            total++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0 || occ8 !== 2'd0 || out_data8 !== 8'h00) begin
                bad++; $display("FAIL mrst_vals p=%0d got v=%0h r=%0h o=%0d d=%0h exp 0/0/0/0",
                                pass, out_valid8, in_ready8, occ8, out_data8);
            end
            rs = 1; fl = 0;
            tick();
            total++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
                bad++; $display("FAIL mrst_release p=%0d got r=%0h v=%0h exp r=1 v=0", pass, in_ready8, out_valid8);
            end
            v8 = 1; d8 = 8'h7A; ordy8 = 1;
            tick();
            total++; if (out_valid8 !== 1'b1 || out_data8 !== 8'h7A) begin
                bad++; $display("FAIL mrst_recover p=%0d got=%0h/%0h exp=1/7a", pass, out_valid8, out_data8);
            end
        end
        v8 = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
